// File: rtl/keypad_scan_buffer.sv
// rtl/keypad_scan_buffer.sv - matrix keypad scan/debounce, hex digit buffer, event port, 7-seg mux
// Optional KEYSCAN_BLANK_EN: blank display positions not yet filled by an accepted key.
module keypad_scan_buffer #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int NDIGITS  = 4,
  parameter int SCANBITS = 3,
  parameter int DEBOUNCE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      cols,
  output logic                 key_valid,
  input  logic                 key_ready,
  output logic [3:0]           key_hex,
  output logic                 overrun,
  output logic [4*NDIGITS-1:0] digits,
  output logic [6:0]           seg,
  output logic [NDIGITS-1:0]   dig_en
);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DW = $clog2(NDIGITS);

  typedef enum logic [1:0] {SCAN, PRESS, HELD, RELEASE} state_t;

  state_t              state;
  logic [SCANBITS-1:0] counter;
  logic [CW-1:0]       col;
  logic [CW-1:0]       col_next;
  logic [1:0]          row_r;
  logic [1:0]          top_r;
  logic [1:0]          accept_row;
  logic [3:0]          cnt;
  logic [3:0]          accept_hex;
  logic [3:0]          shown;
  logic [DW-1:0]       disp;
  logic [DW-1:0]       disp_next;
  logic [6:0]          seg_next;
  logic                tick;
  logic                any_row;
  logic                row_hi;
  logic                accept;
  logic                advance;

  function automatic logic [COLS-1:0] col_onehot(input logic [CW-1:0] idx);
    col_onehot = '0;
    for (int i = 0; i < COLS; i++)
      if (CW'(i) == idx) col_onehot[COLS-1-i] = 1'b1;
  endfunction

  // Indexed by {column, row counted from the top}.
  function automatic logic [3:0] hex_of(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'b0000: hex_of = 4'h1;
      4'b0001: hex_of = 4'h4;
      4'b0010: hex_of = 4'h7;
      4'b0011: hex_of = 4'hE;
      4'b0100: hex_of = 4'h2;
      4'b0101: hex_of = 4'h5;
      4'b0110: hex_of = 4'h8;
      4'b0111: hex_of = 4'h0;
      4'b1000: hex_of = 4'h3;
      4'b1001: hex_of = 4'h6;
      4'b1010: hex_of = 4'h9;
      4'b1011: hex_of = 4'hF;
      4'b1100: hex_of = 4'hA;
      4'b1101: hex_of = 4'hB;
      4'b1110: hex_of = 4'hC;
      default: hex_of = 4'hD;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: seg_of = 7'b1000000;
      4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;
      4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;
      4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;
      4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000;
      4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110;
      4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;
      default: seg_of = 7'b0001110;
    endcase
  endfunction

  assign tick     = &counter;
  assign col_next = (col == CW'(COLS-1)) ? '0 : col + 1'b1;

  // Descending loop so the topmost (lowest index) high row wins.
  always_comb begin
    any_row = |rows;
    top_r   = 2'd0;
    for (int r = ROWS-1; r >= 0; r--)
      if (rows[ROWS-1-r]) top_r = 2'(r);
    row_hi = 1'b0;
    for (int r = 0; r < ROWS; r++)
      if (2'(r) == row_r) row_hi = rows[ROWS-1-r];
  end

  // The detect tick in SCAN counts as the first press sighting.
  always_comb begin
    accept  = 1'b0;
    advance = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          accept  = any_row && (DEBOUNCE == 1);
          advance = !any_row;
        end
        PRESS: begin
          accept  = row_hi && ((5'(cnt) + 5'd2) == 5'(DEBOUNCE));
          advance = !row_hi;
        end
        RELEASE: advance = !row_hi && ((5'(cnt) + 5'd1) == 5'(DEBOUNCE));
        default: ;
      endcase
    end
    accept_row = (state == SCAN) ? top_r : row_r;
    accept_hex = hex_of(2'(col), accept_row);
  end

  always_comb begin
    disp_next = (disp == DW'(NDIGITS-1)) ? '0 : disp + 1'b1;
    shown     = 4'h0;
    for (int i = 0; i < NDIGITS; i++)
      if (DW'(i) == disp_next) shown = digits[4*i +: 4];
  end

`ifdef KEYSCAN_BLANK_EN
  localparam int OW = $clog2(NDIGITS+1);
  localparam logic [6:0] SEG_RST = 7'b1111111;
  logic [OW-1:0] occ;

  always_ff @(posedge clk) begin
    if (reset)
      occ <= '0;
    else if (accept && (occ != OW'(NDIGITS)))
      occ <= occ + 1'b1;
  end

  assign seg_next = (int'(disp_next) >= int'(occ)) ? 7'b1111111 : seg_of(shown);
`else
  localparam logic [6:0] SEG_RST = 7'b1000000;
  assign seg_next = seg_of(shown);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SCAN;
      counter   <= '0;
      col       <= '0;
      cols      <= col_onehot(CW'(0));
      row_r     <= 2'd0;
      cnt       <= 4'd0;
      digits    <= '0;
      key_valid <= 1'b0;
      key_hex   <= 4'h0;
      overrun   <= 1'b0;
      disp      <= '0;
      dig_en    <= {{(NDIGITS-1){1'b0}}, 1'b1};
      seg       <= SEG_RST;
    end else begin
      counter <= counter + 1'b1;

      if (key_valid && key_ready)
        key_valid <= 1'b0;
      if (accept) begin
        digits    <= {digits[4*NDIGITS-5:0], accept_hex};
        key_hex   <= accept_hex;
        key_valid <= 1'b1;
        if (key_valid && !key_ready)
          overrun <= 1'b1;
      end

      if (advance) begin
        col  <= col_next;
        cols <= col_onehot(col_next);
      end

      if (tick) begin
        case (state)
          SCAN: if (any_row) begin
            row_r <= top_r;
            cnt   <= 4'd0;
            state <= (DEBOUNCE == 1) ? HELD : PRESS;
          end
          PRESS: begin
            if (!row_hi)
              state <= SCAN;
            else begin
              cnt <= cnt + 4'd1;
              if (accept) state <= HELD;
            end
          end
          HELD: if (!row_hi) begin
            cnt   <= 4'd0;
            state <= RELEASE;
          end
          default: begin
            if (row_hi)
              state <= HELD;
            else if (advance)
              state <= SCAN;
            else
              cnt <= cnt + 4'd1;
          end
        endcase

        disp   <= disp_next;
        dig_en <= {dig_en[NDIGITS-2:0], dig_en[NDIGITS-1]};
        seg    <= seg_next;
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan_buffer.sv
// tb/tb_keypad_scan_buffer.sv - directed self-checking bench for keypad_scan_buffer (SCANBITS=2)
module tb_keypad_scan_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        key_valid;
  logic        key_ready = 1'b1;
  logic [3:0]  key_hex;
  logic        overrun;
  logic [15:0] digits;
  logic [6:0]  seg;
  logic [3:0]  dig_en;

  logic        key_down = 1'b0;
  logic [3:0]  key_col = 4'b0;
  logic [3:0]  key_row = 4'b0;
  logic [1:0]  tb_ph;
  int          tb_ticks = 0;
  int          total = 0;
  int          bad = 0;
  logic [3:0]  evq[$];
  logic [6:0]  segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  always #5 clk = ~clk;

  // Matrix model: a pressed key connects its row only while its column is driven.
  assign rows = (key_down && ((cols & key_col) != 4'b0)) ? key_row : 4'b0;

  keypad_scan_buffer #(.ROWS(4), .COLS(4), .NDIGITS(4), .SCANBITS(2), .DEBOUNCE(2)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .key_valid(key_valid), .key_ready(key_ready), .key_hex(key_hex), .overrun(overrun),
    .digits(digits), .seg(seg), .dig_en(dig_en)
  );

  always @(posedge clk) tb_ph <= reset ? 2'd0 : tb_ph + 2'd1;
  always @(posedge clk) if (!reset && key_valid && key_ready) evq.push_back(key_hex);

  task automatic step_tick();
    do begin
      @(posedge clk); #1;
    end while (tb_ph != 2'd0);
    tb_ticks++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tb_ticks = 0;
  endtask

  task automatic goto_col(input logic [3:0] target);
    for (int i = 0; i < 8 && cols !== target; i++) step_tick();
    total++;
    if (cols !== target) begin bad++; $display("FAIL goto_col got=%b want=%b", cols, target); end
  endtask

  task automatic press_key(input logic [3:0] cm, input logic [3:0] rm);
    goto_col(cm);
    key_col = cm; key_row = rm; key_down = 1'b1;
    repeat (3) step_tick();
    key_down = 1'b0;
    repeat (3) step_tick();
  endtask

  task automatic test_reset();
    logic [6:0] seg_rst;
`ifdef KEYSCAN_BLANK_EN
    seg_rst = 7'b1111111;
`else
    seg_rst = 7'b1000000;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tb_ticks = 0;
    total++; if (cols !== 4'b1000) begin bad++; $display("FAIL reset_cols got=%b want=1000", cols); end
    total++; if (dig_en !== 4'b0001) begin bad++; $display("FAIL reset_dig_en got=%b want=0001", dig_en); end
    total++; if (seg !== seg_rst) begin bad++; $display("FAIL reset_seg got=%b want=%b", seg, seg_rst); end
    total++; if (key_valid !== 1'b0 || overrun !== 1'b0 || key_hex !== 4'h0)
      begin bad++; $display("FAIL reset_event got=%b%b%h want=000", key_valid, overrun, key_hex); end
    total++; if (digits !== 16'h0) begin bad++; $display("FAIL reset_digits got=%h want=0000", digits); end
  endtask

  task automatic test_idle();
    logic [3:0] ec, ed;
    for (int k = 1; k <= 16; k++) begin
      step_tick();
      ec = 4'b1000 >> (k % 4);
      ed = 4'b0001 << (k % 4);
      total++; if (cols !== ec) begin bad++; $display("FAIL idle_cols t=%0d got=%b want=%b", k, cols, ec); end
      total++; if (dig_en !== ed) begin bad++; $display("FAIL idle_dig_en t=%0d got=%b want=%b", k, dig_en, ed); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL idle_valid t=%0d got=%b want=0", k, key_valid); end
    end
  endtask

  task automatic test_single();
    evq.delete();
    goto_col(4'b0100);
    key_col = 4'b0100; key_row = 4'b0010; key_down = 1'b1;
    step_tick();
    total++; if (cols !== 4'b0100 || key_valid !== 1'b0)
      begin bad++; $display("FAIL single_detect got=%b/%b want=0100/0", cols, key_valid); end
    step_tick();
    total++; if (key_valid !== 1'b1 || key_hex !== 4'h8)
      begin bad++; $display("FAIL single_accept got=%b/%h want=1/8", key_valid, key_hex); end
    total++; if (digits !== 16'h0008) begin bad++; $display("FAIL single_digits got=%h want=0008", digits); end
    @(posedge clk); #1;
    total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL single_pop got=%b want=0", key_valid); end
    for (int k = 0; k < 4; k++) begin
      step_tick();
      total++; if (cols !== 4'b0100) begin bad++; $display("FAIL single_hold_cols k=%0d got=%b want=0100", k, cols); end
    end
    key_down = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step_tick();
      total++; if (cols !== 4'b0100) begin bad++; $display("FAIL single_rel_cols k=%0d got=%b want=0100", k, cols); end
    end
    step_tick();
    total++; if (cols !== 4'b0010) begin bad++; $display("FAIL single_resume got=%b want=0010", cols); end
    total++; if (evq.size() != 1 || evq[0] !== 4'h8)
      begin bad++; $display("FAIL single_events got=%0d events want=1 of 8", evq.size()); end
  endtask

  task automatic test_glitch();
    evq.delete();
    goto_col(4'b1000);
    key_col = 4'b1000; key_row = 4'b1000; key_down = 1'b1;
    step_tick();
    key_down = 1'b0;
    total++; if (cols !== 4'b1000) begin bad++; $display("FAIL glitch_frozen got=%b want=1000", cols); end
    step_tick();
    total++; if (cols !== 4'b0100) begin bad++; $display("FAIL glitch_resume got=%b want=0100", cols); end
    total++; if (key_valid !== 1'b0 || evq.size() != 0)
      begin bad++; $display("FAIL glitch_event got=%b/%0d want=0/0", key_valid, evq.size()); end
  endtask

  task automatic test_sequence();
    logic [19:0] got;
    evq.delete();
    press_key(4'b1000, 4'b1000);
    press_key(4'b0100, 4'b1000);
    press_key(4'b0010, 4'b1000);
    press_key(4'b1000, 4'b0100);
    press_key(4'b0100, 4'b0100);
    total++; if (digits !== 16'h2345) begin bad++; $display("FAIL seq_digits got=%h want=2345", digits); end
    got = '0;
    foreach (evq[i]) got = {got[15:0], evq[i]};
    total++; if (evq.size() != 5 || got !== 20'h12345)
      begin bad++; $display("FAIL seq_events got=%0d/%h want=5/12345", evq.size(), got); end
  endtask

  task automatic test_overrun();
    key_ready = 1'b0;
    press_key(4'b1000, 4'b0010);
    total++; if (key_valid !== 1'b1 || key_hex !== 4'h7 || overrun !== 1'b0)
      begin bad++; $display("FAIL ovr_first got=%b/%h/%b want=1/7/0", key_valid, key_hex, overrun); end
    press_key(4'b0010, 4'b0010);
    total++; if (key_valid !== 1'b1 || key_hex !== 4'h9 || overrun !== 1'b1)
      begin bad++; $display("FAIL ovr_second got=%b/%h/%b want=1/9/1", key_valid, key_hex, overrun); end
    total++; if (digits !== 16'h4579) begin bad++; $display("FAIL ovr_digits got=%h want=4579", digits); end
    key_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (key_valid !== 1'b0 || overrun !== 1'b1)
      begin bad++; $display("FAIL ovr_pop got=%b/%b want=0/1", key_valid, overrun); end
  endtask

  task automatic test_display();
    logic [15:0] ed;
    logic [3:0]  en;
    int p;
    ed = 16'h4579;
    for (int k = 0; k < 4; k++) begin
      step_tick();
      p  = tb_ticks % 4;
      en = 4'b0001 << p;
      total++; if (dig_en !== en || seg !== segtab[ed[4*p +: 4]])
        begin bad++; $display("FAIL disp p=%0d got=%b/%b want=%b/%b", p, dig_en, seg, en, segtab[ed[4*p +: 4]]); end
    end
  endtask

  task automatic test_reset_mid();
    goto_col(4'b0001);
    key_col = 4'b0001; key_row = 4'b0001; key_down = 1'b1;
    step_tick();
    do_reset();
    total++; if (cols !== 4'b1000 || key_valid !== 1'b0 || overrun !== 1'b0 || digits !== 16'h0)
      begin bad++; $display("FAIL mid_reset got=%b/%b/%b/%h want=1000/0/0/0000", cols, key_valid, overrun, digits); end
    repeat (4) step_tick();
    total++; if (key_valid !== 1'b0 || cols !== 4'b0001)
      begin bad++; $display("FAIL mid_redetect got=%b/%b want=0/0001", key_valid, cols); end
    step_tick();
    total++; if (key_valid !== 1'b1 || key_hex !== 4'hD || digits !== 16'h000D)
      begin bad++; $display("FAIL mid_reaccept got=%b/%h/%h want=1/d/000d", key_valid, key_hex, digits); end
    key_down = 1'b0;
    repeat (3) step_tick();
  endtask

`ifdef KEYSCAN_BLANK_EN
  task automatic test_blank();
    logic [6:0] es;
    int p;
    do_reset();
    press_key(4'b1000, 4'b0001);
    total++; if (digits !== 16'h000E) begin bad++; $display("FAIL blank_digits got=%h want=000e", digits); end
    for (int k = 0; k < 4; k++) begin
      step_tick();
      p  = tb_ticks % 4;
      es = (p == 0) ? 7'b0000110 : 7'b1111111;
      total++; if (seg !== es) begin bad++; $display("FAIL blank_seg p=%0d got=%b want=%b", p, seg, es); end
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_glitch();
    test_sequence();
    test_overrun();
    test_display();
    test_reset_mid();
`ifdef KEYSCAN_BLANK_EN
    test_blank();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
